// File: rtl/data_recv_if.sv
// Byte-in / FIFO-write bundle for the receive framer.
// master is the framer side; slave is the UART/FIFO environment side.
interface data_recv_if;
  logic [7:0] iData;
  logic       iNewData;
  logic       full;
  logic [7:0] oData;
  logic       oWrclk;
  logic       oFrameDone;
  logic       oTimeout;
  logic       oOverrun;
  logic       oBusy;

  modport master (
    input  iData, iNewData, full,
    output oData, oWrclk, oFrameDone, oTimeout, oOverrun, oBusy
  );

  modport slave (
    output iData, iNewData, full,
    input  oData, oWrclk, oFrameDone, oTimeout, oOverrun, oBusy
  );
endinterface

// File: rtl/data_recv.sv
// Receive framer: moves UART bytes into the FIFO, counts them into N-byte
// frames, aborts a stalled partial frame after TIMEOUT idle cycles.
module data_recv #(
  parameter int N       = 32,
  parameter int TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         rst,
  data_recv_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          TW     = $clog2(TIMEOUT + 1);
  localparam logic [9:0]  N_VAL  = 10'(N);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  state_t          state_r;
  state_t          state_s;
  logic [9:0]      cnt_r;
  logic [9:0]      cnt_inc_s;
  logic [TW-1:0]   to_cnt_r;
  logic [7:0]      cur_r;
  logic [7:0]      pend_data_r;
  logic            pend_valid_r;
  logic            take_pend_s;
  logic            take_new_s;
  logic            counting_s;
  logic            fire_s;
  logic            drop_s;
  logic [7:0]      data_r;
  logic            wrclk_r;
  logic            frame_done_r;
  logic            timeout_r;
  logic            overrun_r;
  logic            busy_r;

  assign cnt_inc_s  = cnt_r + 10'd1;
  // A new strobe in IDLE means the timer is about to be cleared by LATCH entry.
  assign counting_s = (state_r == IDLE) && (cnt_r != 10'd0) && (cnt_r < N_VAL)
                      && !pend_valid_r && !bus.iNewData;
  assign fire_s     = counting_s && (to_cnt_r == TO_MAX);
  assign drop_s     = bus.iNewData && (state_r != IDLE) && pend_valid_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and byte-source selection
  always_comb begin
    state_s     = state_r;
    take_pend_s = 1'b0;
    take_new_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_valid_r) begin
          state_s     = LATCH;
          take_pend_s = 1'b1;
        end else if (bus.iNewData) begin
          state_s    = LATCH;
          take_new_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LATCH: state_s = WRITE;
      WRITE: begin
        if (cnt_inc_s == N_VAL) begin
          state_s = DONE;
        end else begin
          state_s = IDLE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One-entry pending buffer for bytes that arrive while a byte is in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_valid_r <= 1'b0;
      pend_data_r  <= 8'h00;
    end else if ((state_r == IDLE) && pend_valid_r) begin
      pend_valid_r <= bus.iNewData;
      if (bus.iNewData) begin
        pend_data_r <= bus.iData;
      end
    end else if ((state_r != IDLE) && bus.iNewData && !pend_valid_r) begin
      pend_valid_r <= 1'b1;
      pend_data_r  <= bus.iData;
    end
  end

  // Datapath, frame counter, inter-byte timer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_r        <= 8'h00;
      data_r       <= 8'h00;
      wrclk_r      <= 1'b0;
      frame_done_r <= 1'b0;
      timeout_r    <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
      cnt_r        <= 10'd0;
      to_cnt_r     <= {TW{1'b0}};
    end else begin
      wrclk_r      <= (state_r == LATCH) && !bus.full;
      frame_done_r <= (state_r == WRITE) && (cnt_inc_s == N_VAL);
      timeout_r    <= fire_s;
      busy_r       <= (cnt_r != 10'd0);
      if (take_pend_s) begin
        cur_r <= pend_data_r;
      end else if (take_new_s) begin
        cur_r <= bus.iData;
      end
      if (state_r == LATCH) begin
        data_r <= cur_r;
      end
      if (((state_r == LATCH) && bus.full) || drop_s) begin
        overrun_r <= 1'b1;
      end
      // A byte dropped at a full FIFO still counts toward the frame.
      if (state_r == WRITE) begin
        cnt_r <= cnt_inc_s;
      end else if ((state_r == DONE) || fire_s) begin
        cnt_r <= 10'd0;
      end
      if (counting_s) begin
        if (to_cnt_r != TO_MAX) begin
          to_cnt_r <= to_cnt_r + TW'(1);
        end
      end else begin
        to_cnt_r <= {TW{1'b0}};
      end
    end
  end

  assign bus.oData      = data_r;
  assign bus.oWrclk     = wrclk_r;
  assign bus.oFrameDone = frame_done_r;
  assign bus.oTimeout   = timeout_r;
  assign bus.oOverrun   = overrun_r;
  assign bus.oBusy      = busy_r;

endmodule

// File: tb/tb_data_recv.sv
// Directed bench for data_recv (N=4, TIMEOUT=10): per-cycle output log
// sampled on the falling edge, checked against hand-computed cycle offsets.
module tb_data_recv;
  localparam int LOGN = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [7:0] data_log [0:LOGN-1];
  logic       wr_log   [0:LOGN-1];
  logic       fd_log   [0:LOGN-1];
  logic       to_log   [0:LOGN-1];
  logic       ovr_log  [0:LOGN-1];
  logic       busy_log [0:LOGN-1];

  data_recv_if bus ();

  data_recv #(.N(4), .TIMEOUT(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      data_log[cyc] <= bus.oData;
      wr_log[cyc]   <= bus.oWrclk;
      fd_log[cyc]   <= bus.oFrameDone;
      to_log[cyc]   <= bus.oTimeout;
      ovr_log[cyc]  <= bus.oOverrun;
      busy_log[cyc] <= bus.oBusy;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] b, output int at);
    at           = cyc;
    bus.iData    = b;
    bus.iNewData = 1'b1;
    @(posedge clk);
    #1;
    bus.iNewData = 1'b0;
    bus.iData    = 8'h00;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.iNewData = 1'b0;
    bus.iData = 8'h00;
    bus.full = 1'b0;
    idle(2);
    total++; if (bus.oData !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.oData); end
    total++; if (bus.oWrclk !== 1'b0) begin bad++; $display("FAIL reset_wrclk got=%b exp=0", bus.oWrclk); end
    total++; if (bus.oFrameDone !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", bus.oFrameDone); end
    total++; if (bus.oTimeout !== 1'b0) begin bad++; $display("FAIL reset_to got=%b exp=0", bus.oTimeout); end
    total++; if (bus.oOverrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", bus.oOverrun); end
    total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.oBusy); end
    rst = 1'b1;
    idle(2);
  endtask

  // Spacing of 8 keeps each gap below the 10-cycle timeout.
  task automatic test_frame();
    logic [7:0] b [4];
    int s [4];
    int n;
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      strobe(b[k], s[k]);
      idle(7);
    end
    idle(10);
    for (int k = 0; k < 4; k++) begin
      total++; if (wr_log[s[k]+2] !== 1'b1) begin bad++; $display("FAIL frame_wr%0d got=%b exp=1", k, wr_log[s[k]+2]); end
      total++; if (data_log[s[k]+2] !== b[k]) begin bad++; $display("FAIL frame_data%0d got=%h exp=%h", k, data_log[s[k]+2], b[k]); end
      total++; if (wr_log[s[k]+1] !== 1'b0 || wr_log[s[k]+3] !== 1'b0) begin bad++; $display("FAIL frame_wrwidth%0d got=%b%b exp=00", k, wr_log[s[k]+1], wr_log[s[k]+3]); end
    end
    n = 0;
    for (int c = s[0]; c <= s[3] + 10; c++) if (fd_log[c] === 1'b1) n++;
    total++; if (n != 1) begin bad++; $display("FAIL frame_fdcount got=%0d exp=1", n); end
    total++; if (fd_log[s[3]+3] !== 1'b1) begin bad++; $display("FAIL frame_fd got=%b exp=1", fd_log[s[3]+3]); end
    total++; if (busy_log[s[0]+3] !== 1'b0 || busy_log[s[0]+4] !== 1'b1) begin bad++; $display("FAIL frame_busy_rise got=%b%b exp=01", busy_log[s[0]+3], busy_log[s[0]+4]); end
    total++; if (busy_log[s[3]+4] !== 1'b1 || busy_log[s[3]+5] !== 1'b0) begin bad++; $display("FAIL frame_busy_fall got=%b%b exp=10", busy_log[s[3]+4], busy_log[s[3]+5]); end
    total++; if (bus.oOverrun !== 1'b0) begin bad++; $display("FAIL frame_ovr got=%b exp=0", bus.oOverrun); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] b [4];
    int s [4];
    b = '{8'h55, 8'h66, 8'h77, 8'h88};
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        bus.full = 1'b1;
        strobe(b[k], s[k]);
        idle(1);
        bus.full = 1'b0;
        idle(6);
      end else begin
        strobe(b[k], s[k]);
        idle(7);
      end
    end
    idle(10);
    total++; if (wr_log[s[1]+2] !== 1'b0) begin bad++; $display("FAIL full_nowr got=%b exp=0", wr_log[s[1]+2]); end
    total++; if (ovr_log[s[1]+1] !== 1'b0 || ovr_log[s[1]+2] !== 1'b1) begin bad++; $display("FAIL full_ovr_edge got=%b%b exp=01", ovr_log[s[1]+1], ovr_log[s[1]+2]); end
    total++; if (wr_log[s[2]+2] !== 1'b1 || data_log[s[2]+2] !== 8'h77) begin bad++; $display("FAIL full_next got=%b/%h exp=1/77", wr_log[s[2]+2], data_log[s[2]+2]); end
    total++; if (fd_log[s[3]+3] !== 1'b1) begin bad++; $display("FAIL full_fd got=%b exp=1", fd_log[s[3]+3]); end
    total++; if (bus.oOverrun !== 1'b1) begin bad++; $display("FAIL full_sticky got=%b exp=1", bus.oOverrun); end
  endtask

  task automatic test_back_to_back();
    int s0, s1, s2, n;
    pulse_reset();
    strobe(8'hA5, s0);
    strobe(8'h5A, s1);
    strobe(8'hC3, s2);
    idle(12);
    total++; if (wr_log[s0+2] !== 1'b1 || data_log[s0+2] !== 8'hA5) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/a5", wr_log[s0+2], data_log[s0+2]); end
    total++; if (data_log[s0+4] !== 8'hA5) begin bad++; $display("FAIL b2b_hold got=%h exp=a5", data_log[s0+4]); end
    total++; if (wr_log[s0+5] !== 1'b1 || data_log[s0+5] !== 8'h5A) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/5a", wr_log[s0+5], data_log[s0+5]); end
    n = 0;
    for (int c = s0; c <= s0 + 13; c++) if (wr_log[c] === 1'b1) n++;
    total++; if (n != 2) begin bad++; $display("FAIL b2b_wrcount got=%0d exp=2", n); end
    total++; if (ovr_log[s0+2] !== 1'b0 || ovr_log[s0+3] !== 1'b1) begin bad++; $display("FAIL b2b_drop_ovr got=%b%b exp=01", ovr_log[s0+2], ovr_log[s0+3]); end
  endtask

  task automatic test_timeout();
    int s0, s1, n, m;
    int f [4];
    logic [7:0] b [4];
    b = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    pulse_reset();
    strobe(8'h9A, s0);
    idle(4);
    strobe(8'h9B, s1);
    idle(20);
    total++; if (to_log[s1+13] !== 1'b0 || to_log[s1+14] !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b%b exp=01", to_log[s1+13], to_log[s1+14]); end
    n = 0;
    for (int c = s0; c <= s1 + 20; c++) if (to_log[c] === 1'b1) n++;
    total++; if (n != 1) begin bad++; $display("FAIL to_count got=%0d exp=1", n); end
    total++; if (busy_log[s1+14] !== 1'b1 || busy_log[s1+15] !== 1'b0) begin bad++; $display("FAIL to_busy got=%b%b exp=10", busy_log[s1+14], busy_log[s1+15]); end
    for (int k = 0; k < 4; k++) begin
      strobe(b[k], f[k]);
      idle(3);
    end
    idle(8);
    n = 0;
    m = 0;
    for (int c = f[0]; c <= f[3] + 8; c++) begin
      if (fd_log[c] === 1'b1) n++;
      if (to_log[c] === 1'b1) m++;
    end
    total++; if (fd_log[f[3]+3] !== 1'b1 || n != 1) begin bad++; $display("FAIL to_refill_fd got=%b/%0d exp=1/1", fd_log[f[3]+3], n); end
    total++; if (m != 0) begin bad++; $display("FAIL to_refill_noto got=%0d exp=0", m); end
  endtask

  task automatic test_reset_midframe();
    int s0, s1, n, w;
    int f [4];
    logic [7:0] b [4];
    b = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    pulse_reset();
    strobe(8'hC1, s0);
    idle(3);
    strobe(8'hC2, s1);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(5);
    total++; if (wr_log[s1+2] !== 1'b0 || wr_log[s1+3] !== 1'b0) begin bad++; $display("FAIL rmid_nowr got=%b%b exp=00", wr_log[s1+2], wr_log[s1+3]); end
    total++; if (data_log[s1+2] !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h exp=00", data_log[s1+2]); end
    total++; if (busy_log[s1+2] !== 1'b0 || ovr_log[s1+2] !== 1'b0) begin bad++; $display("FAIL rmid_flags got=%b%b exp=00", busy_log[s1+2], ovr_log[s1+2]); end
    for (int k = 0; k < 4; k++) begin
      strobe(b[k], f[k]);
      idle(3);
    end
    idle(8);
    n = 0;
    w = 0;
    for (int c = f[0]; c <= f[3] + 8; c++) begin
      if (fd_log[c] === 1'b1) n++;
      if (wr_log[c] === 1'b1) w++;
    end
    total++; if (fd_log[f[3]+3] !== 1'b1 || n != 1) begin bad++; $display("FAIL rmid_fd got=%b/%0d exp=1/1", fd_log[f[3]+3], n); end
    total++; if (w != 4) begin bad++; $display("FAIL rmid_wrcount got=%0d exp=4", w); end
  endtask

  initial begin
    bus.iData    = 8'h00;
    bus.iNewData = 1'b0;
    bus.full     = 1'b0;
    #1;
    test_reset();
    test_frame();
    test_fifo_full();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
